vending_ctrl: RTL and testbench
===============================

VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 SHALL have parameter N_ITEMS, default 4, number of selectable products (2..8).
REQ-002 SHALL have parameter PRICES, default 32'h140C_0803, packed 8-bit unit prices with item i at [8i+7:8i] (defaults 3, 8, 12, 20).
REQ-003 SHALL have parameter QTY_W, default 4, per-item quantity counter width.
REQ-004 SHALL have parameter TIME_1S, default 50_000_000, clock cycles per second tick.
REQ-005 SHALL have parameters OUT_SEC, default 5, and WAIT_SEC, default 5, giving OUT and WAIT durations in seconds.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports key_sel, key_inc, key_ok, key_cancel, key_coin1, key_coin5, each input, 1, single-cycle debounced key pulses.
REQ-009 SHALL have port state, output, 6, one-hot state: IDLE=000001, SELECT=000010, INCOIN=000100, WAIT=001000, OUT=010000, RETURN=100000.
REQ-010 SHALL have port sel_idx, output, $clog2(N_ITEMS), currently selected item.
REQ-011 SHALL have port qty_sel, output, QTY_W, quantity of the selected item.
REQ-012 SHALL have ports total, money_in, and change, each output, 10, order price, credit, and remaining change.
REQ-013 SHALL have ports coin5_ret and coin1_ret, each output, 1, one-cycle coin dispense pulses.
REQ-014 SHALL have ports led (output, 4) and beep_en (output, 1).

Function
REQ-015 SHALL move IDLE->SELECT on key_sel, with sel_idx=0.
REQ-016 SHALL, in SELECT, advance sel_idx on key_sel, wrapping N_ITEMS-1->0.
REQ-017 SHALL, in SELECT, increment qty[sel_idx] on key_inc, saturating at 2^QTY_W-1.
REQ-018 SHALL compute total as the registered sum of qty[i]*price[i], 1-cycle latency, saturating at 1023.
REQ-019 SHALL, in SELECT, go to INCOIN on key_ok if total>0, else stay in SELECT.
REQ-020 SHALL, in SELECT, go to IDLE on key_cancel and clear all quantities.
REQ-021 SHALL, in INCOIN and WAIT only, add 1 on key_coin1, add 5 on key_coin5, add 6 when both occur, saturating money_in at 1023.
REQ-022 SHALL, in INCOIN on key_ok, go to OUT if money_in>=total, else to WAIT.
REQ-023 SHALL, in INCOIN or WAIT on key_cancel, go to RETURN with change=money_in (full refund).
REQ-024 SHALL, at WAIT expiry (WAIT_SEC ticks), go to OUT if money_in>=total, else to RETURN with change=money_in.
REQ-025 SHALL, at OUT expiry (OUT_SEC ticks), go to RETURN with change=money_in-total and pulse beep_en for 1 cycle.
REQ-026 SHALL, in RETURN each cycle, pulse coin5_ret and subtract 5 if change>=5, else pulse coin1_ret and subtract 1 if change>=1.
REQ-027 SHALL, in RETURN with change==0, go to IDLE, emit no coin pulse, and clear qty, money_in, sel_idx, and led.
REQ-028 SHALL run the tick counter only in WAIT/OUT, clearing the cycle and second counters on every state change.
REQ-029 SHALL, in OUT, rotate led left on each tick as {led[2:0],~led[3]} from 0000.
REQ-030 SHALL, in WAIT, rotate led right on each tick as {~led[0],led[3:1]}.
REQ-031 SHALL apply same-cycle key priority key_cancel > key_ok > key_sel > key_inc; coins are processed in the same cycle as key_ok, and the comparison uses the pre-add money_in.
REQ-032 SHALL ignore keys in states where they are not listed.
REQ-033 SHALL never assert coin5_ret and coin1_ret in the same cycle.

Reset
REQ-034 SHALL, while rst=1 at a clock edge, force state=IDLE, all counters/qty/money_in/total/change/sel_idx=0, led=0000, and beep_en, coin5_ret, coin1_ret=0.
REQ-035 SHALL let reset mid-RETURN abort dispensing with no further coin pulses.

Verification (TIME_1S=10, defaults otherwise)
REQ-036 SHALL cover: sel, inc x2 (item0), sel, inc (item1), ok, coin5 x3, ok -> total=14, OUT for 50 cycles, change=1, one coin1_ret pulse, IDLE.
REQ-037 SHALL cover: item1 x1, coin1 x2, ok -> WAIT; coin5 within 50 cycles -> OUT, then change=7 dispensed as coin5 then coin1 x2.
REQ-038 SHALL cover: item3 x1, coin5 x1, ok -> WAIT; no coins -> after 50 cycles RETURN, one coin5_ret pulse, IDLE.
REQ-039 SHALL cover: key_inc x20 on item0 -> qty_sel=15 and total=45; key_sel x4 -> sel_idx wraps to 0.
REQ-040 SHALL cover: key_coin1 and key_coin5 in the same cycle -> money_in +6; key_ok with key_cancel in the same cycle -> RETURN.
REQ-041 SHALL cover: rst asserted during RETURN with change=12 -> next cycle IDLE, outputs zero, no coin pulses.

Source files
------------

// File: rtl/vending_ctrl.sv
`default_nettype none
// ============================================================================
// vending_ctrl : multi-item vending machine controller with coin credit,
//                timed dispense/wait phases and coin-by-coin change return.
// Revision     : 1.0
// ============================================================================
module vending_ctrl #(
  parameter int                   N_ITEMS  = 4,
  parameter logic [8*N_ITEMS-1:0] PRICES   = 32'h140C_0803,
  parameter int                   QTY_W    = 4,
  parameter int                   TIME_1S  = 50_000_000,
  parameter int                   OUT_SEC  = 5,
  parameter int                   WAIT_SEC = 5,
  localparam int                  SEL_W    = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sel,
  input  logic             key_inc,
  input  logic             key_ok,
  input  logic             key_cancel,
  input  logic             key_coin1,
  input  logic             key_coin5,
  output logic [5:0]       state,
  output logic [SEL_W-1:0] sel_idx,
  output logic [QTY_W-1:0] qty_sel,
  output logic [9:0]       total,
  output logic [9:0]       money_in,
  output logic [9:0]       change,
  output logic             coin5_ret,
  output logic             coin1_ret,
  output logic [3:0]       led,
  output logic             beep_en
);

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_SELECT = 6'b000010,
    ST_INCOIN = 6'b000100,
    ST_WAIT   = 6'b001000,
    ST_OUT    = 6'b010000,
    ST_RETURN = 6'b100000
  } state_t;

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_ITEMS - 1);

  state_t           state_q,  state_d;
  logic [SEL_W-1:0] sel_q,    sel_d;
  logic [QTY_W-1:0] qty_q [N_ITEMS];
  logic [QTY_W-1:0] qty_d [N_ITEMS];
  logic [9:0]       total_q,  total_d;
  logic [9:0]       money_q,  money_d;
  logic [9:0]       change_q, change_d;
  logic [3:0]       led_q,    led_d;
  logic             beep_q,   beep_d;
  logic             coin5_q,  coin5_d;
  logic             coin1_q,  coin1_d;
  logic [31:0]      cyc_q,    cyc_d;
  logic [31:0]      sec_q,    sec_d;

  logic [31:0] sum;
  logic [2:0]  coin_add;
  logic [10:0] money_sum;
  logic [9:0]  money_plus;
  logic        timed;
  logic        tick;
  logic        expire;
  logic [31:0] dur;

  // Order price is recomputed every cycle from the quantity table.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      sum = sum + 32'(qty_q[i]) * 32'(PRICES[8*i +: 8]);
    end
    total_d = (sum > 32'd1023) ? 10'd1023 : sum[9:0];
  end

  always_comb begin
    coin_add   = (key_coin1 ? 3'd1 : 3'd0) + (key_coin5 ? 3'd5 : 3'd0);
    money_sum  = 11'(money_q) + 11'(coin_add);
    money_plus = (money_sum > 11'd1023) ? 10'd1023 : money_sum[9:0];
    timed      = (state_q == ST_WAIT) || (state_q == ST_OUT);
    tick       = timed && (cyc_q == 32'(TIME_1S - 1));
    dur        = (state_q == ST_OUT) ? 32'(OUT_SEC) : 32'(WAIT_SEC);
    expire     = tick && (sec_q == dur - 32'd1);
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    qty_d    = qty_q;
    money_d  = money_q;
    change_d = change_q;
    led_d    = led_q;
    beep_d   = 1'b0;
    coin5_d  = 1'b0;
    coin1_d  = 1'b0;

    if (tick) begin
      led_d = (state_q == ST_OUT) ? {led_q[2:0], ~led_q[3]} : {~led_q[0], led_q[3:1]};
    end

    case (state_q)
      ST_IDLE: begin
        if (key_sel) begin
          state_d = ST_SELECT;
          sel_d   = '0;
        end
      end
      ST_SELECT: begin
        if (key_cancel) begin
          state_d = ST_IDLE;
          for (int i = 0; i < N_ITEMS; i++) qty_d[i] = '0;
        end else if (key_ok) begin
          if (total_q != 10'd0) state_d = ST_INCOIN;
        end else if (key_sel) begin
          sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
        end else if (key_inc) begin
          if (!(&qty_q[sel_q])) qty_d[sel_q] = qty_q[sel_q] + QTY_W'(1);
        end
      end
      ST_INCOIN: begin
        if (key_cancel) begin
          state_d  = ST_RETURN;
          change_d = money_q;
        end else begin
          money_d = money_plus;
          // Sufficiency is judged on the credit held before this cycle's coins.
          if (key_ok) state_d = (money_q >= total_q) ? ST_OUT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (key_cancel) begin
          state_d  = ST_RETURN;
          change_d = money_q;
        end else begin
          money_d = money_plus;
          if (expire) begin
            if (money_q >= total_q) begin
              state_d = ST_OUT;
            end else begin
              state_d  = ST_RETURN;
              change_d = money_q;
            end
          end
        end
      end
      ST_OUT: begin
        if (expire) begin
          state_d  = ST_RETURN;
          change_d = money_q - total_q;
          beep_d   = 1'b1;
        end
      end
      ST_RETURN: begin
        if (change_q >= 10'd5) begin
          coin5_d  = 1'b1;
          change_d = change_q - 10'd5;
        end else if (change_q != 10'd0) begin
          coin1_d  = 1'b1;
          change_d = change_q - 10'd1;
        end else begin
          state_d = ST_IDLE;
          money_d = '0;
          sel_d   = '0;
          led_d   = 4'b0000;
          for (int i = 0; i < N_ITEMS; i++) qty_d[i] = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_OUT) && (state_q != ST_OUT)) led_d = 4'b0000;

    if ((state_d != state_q) || !timed) begin
      cyc_d = '0;
      sec_d = '0;
    end else if (tick) begin
      cyc_d = '0;
      sec_d = sec_q + 32'd1;
    end else begin
      cyc_d = cyc_q + 32'd1;
      sec_d = sec_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      for (int i = 0; i < N_ITEMS; i++) qty_q[i] <= '0;
      total_q  <= '0;
      money_q  <= '0;
      change_q <= '0;
      led_q    <= 4'b0000;
      beep_q   <= 1'b0;
      coin5_q  <= 1'b0;
      coin1_q  <= 1'b0;
      cyc_q    <= '0;
      sec_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      qty_q    <= qty_d;
      total_q  <= total_d;
      money_q  <= money_d;
      change_q <= change_d;
      led_q    <= led_d;
      beep_q   <= beep_d;
      coin5_q  <= coin5_d;
      coin1_q  <= coin1_d;
      cyc_q    <= cyc_d;
      sec_q    <= sec_d;
    end
  end

  assign state     = state_q;
  assign sel_idx   = sel_q;
  assign qty_sel   = qty_q[sel_q];
  assign total     = total_q;
  assign money_in  = money_q;
  assign change    = change_q;
  assign coin5_ret = coin5_q;
  assign coin1_ret = coin1_q;
  assign led       = led_q;
  assign beep_en   = beep_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_ctrl.sv
`default_nettype none
// ============================================================================
// tb_vending_ctrl : directed purchase scenarios against a cycle-level model.
// Revision        : 1.0
// ============================================================================
module tb_vending_ctrl;

  localparam int N_ITEMS  = 4;
  localparam int QTY_W    = 4;
  localparam int TIME_1S  = 10;
  localparam int OUT_SEC  = 5;
  localparam int WAIT_SEC = 5;
  localparam logic [31:0] PRICES = 32'h140C_0803;

  localparam int S_IDLE = 1, S_SEL = 2, S_INC = 4, S_WAIT = 8, S_OUT = 16, S_RET = 32;

  // Key vector bit order: {coin5, coin1, cancel, ok, inc, sel}
  localparam logic [5:0] K_SEL = 6'b000001, K_INC = 6'b000010, K_OK = 6'b000100;
  localparam logic [5:0] K_CAN = 6'b001000, K_C1  = 6'b010000, K_C5 = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] keys = '0;
  logic [5:0] state;
  logic [1:0] sel_idx;
  logic [3:0] qty_sel;
  logic [9:0] total, money_in, change;
  logic       coin5_ret, coin1_ret, beep_en;
  logic [3:0] led;

  always #5 clk = ~clk;

  vending_ctrl #(
    .N_ITEMS(N_ITEMS), .PRICES(PRICES), .QTY_W(QTY_W),
    .TIME_1S(TIME_1S), .OUT_SEC(OUT_SEC), .WAIT_SEC(WAIT_SEC)
  ) dut (
    .clk(clk), .rst(rst),
    .key_sel(keys[0]), .key_inc(keys[1]), .key_ok(keys[2]),
    .key_cancel(keys[3]), .key_coin1(keys[4]), .key_coin5(keys[5]),
    .state(state), .sel_idx(sel_idx), .qty_sel(qty_sel),
    .total(total), .money_in(money_in), .change(change),
    .coin5_ret(coin5_ret), .coin1_ret(coin1_ret),
    .led(led), .beep_en(beep_en)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int ms, msel, mtotal, mmoney, mchange, mled, mbeep, mc5, mc1, mel;
  int mq [N_ITEMS];
  bit started = 1'b0;

  function automatic int price(input int i);
    return int'((PRICES >> (8 * i)) & 32'hFF);
  endfunction

  // LED pattern after k whole seconds in OUT (counting up) or WAIT (counting down).
  function automatic int led_pat(input bit is_out, input int k);
    int t;
    t = k % 8;
    if (is_out) begin
      case (t) 0: return 0; 1: return 1; 2: return 3; 3: return 7;
               4: return 15; 5: return 14; 6: return 12; default: return 8; endcase
    end else begin
      case (t) 0: return 0; 1: return 8; 2: return 12; 3: return 14;
               4: return 15; 5: return 7; 6: return 3; default: return 1; endcase
    end
  endfunction

  always @(posedge clk) begin : model
    int nt, ns, coins, dur;
    int nled;
    bit timed, expired;
    started = 1'b1;
    if (rst) begin
      ms = S_IDLE; msel = 0; mtotal = 0; mmoney = 0; mchange = 0;
      mled = 0; mbeep = 0; mc5 = 0; mc1 = 0; mel = 0;
      for (int i = 0; i < N_ITEMS; i++) mq[i] = 0;
    end else begin
      nt = 0;
      for (int i = 0; i < N_ITEMS; i++) nt += mq[i] * price(i);
      if (nt > 1023) nt = 1023;
      ns = ms; mbeep = 0; mc5 = 0; mc1 = 0;
      coins   = (keys[4] ? 1 : 0) + (keys[5] ? 5 : 0);
      timed   = (ms == S_WAIT) || (ms == S_OUT);
      dur     = ((ms == S_OUT) ? OUT_SEC : WAIT_SEC) * TIME_1S;
      expired = timed && (mel == dur - 1);
      nled    = mled;
      if (timed) nled = led_pat(ms == S_OUT, (mel + 1) / TIME_1S);
      case (ms)
        S_IDLE: if (keys[0]) begin ns = S_SEL; msel = 0; end
        S_SEL: begin
          if (keys[3]) begin
            ns = S_IDLE;
            for (int i = 0; i < N_ITEMS; i++) mq[i] = 0;
          end else if (keys[2]) begin
            if (mtotal > 0) ns = S_INC;
          end else if (keys[0]) begin
            msel = (msel + 1) % N_ITEMS;
          end else if (keys[1]) begin
            if (mq[msel] < (1 << QTY_W) - 1) mq[msel] = mq[msel] + 1;
          end
        end
        S_INC, S_WAIT: begin
          if (keys[3]) begin
            ns = S_RET; mchange = mmoney;
          end else begin
            if (ms == S_INC && keys[2]) ns = (mmoney >= mtotal) ? S_OUT : S_WAIT;
            if (ms == S_WAIT && expired) begin
              if (mmoney >= mtotal) ns = S_OUT;
              else begin ns = S_RET; mchange = mmoney; end
            end
            mmoney = (mmoney + coins > 1023) ? 1023 : mmoney + coins;
          end
        end
        S_OUT: if (expired) begin ns = S_RET; mchange = mmoney - mtotal; mbeep = 1; end
        default: begin
          if (mchange >= 5) begin mc5 = 1; mchange -= 5; end
          else if (mchange >= 1) begin mc1 = 1; mchange -= 1; end
          else begin
            ns = S_IDLE; mmoney = 0; msel = 0; nled = 0;
            for (int i = 0; i < N_ITEMS; i++) mq[i] = 0;
          end
        end
      endcase
      if (ns == S_OUT && ms != S_OUT) nled = 0;
      mel    = (ns != ms) ? 0 : mel + 1;
      ms     = ns;
      mtotal = nt;
      mled   = nled;
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  int n_c5 = 0, n_c1 = 0, n_beep = 0, n_out = 0, n_wait = 0;

  always @(negedge clk) begin
    if (started) begin
      check("state",     int'(state),     ms);
      check("sel_idx",   int'(sel_idx),   msel);
      check("qty_sel",   int'(qty_sel),   mq[msel]);
      check("total",     int'(total),     mtotal);
      check("money_in",  int'(money_in),  mmoney);
      check("change",    int'(change),    mchange);
      check("led",       int'(led),       mled);
      check("beep_en",   int'(beep_en),   mbeep);
      check("coin5_ret", int'(coin5_ret), mc5);
      check("coin1_ret", int'(coin1_ret), mc1);
      check("coin_excl", int'(coin5_ret & coin1_ret), 0);
      n_c5   += int'(coin5_ret);
      n_c1   += int'(coin1_ret);
      n_beep += int'(beep_en);
      n_out  += (state == 6'(S_OUT))  ? 1 : 0;
      n_wait += (state == 6'(S_WAIT)) ? 1 : 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic hit(input logic [5:0] k);
    @(negedge clk); keys = k;
    @(negedge clk); keys = '0;
  endtask

  task automatic press(input logic [5:0] k);
    hit(k);
    @(negedge clk);
  endtask

  task automatic wait_state(input int target, input int budget, input string name);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state), target);
  endtask

  int c5_0, c1_0, b0, o0, w0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", int'(state), S_IDLE);
    check("reset_total", int'(total), 0);
    check("reset_led",   int'(led), 0);
    check("reset_coins", int'({coin5_ret, coin1_ret, beep_en}), 0);
    rst = 1'b0;

    // Two of item0 plus one of item1, pay 15, expect 1 back.
    press(K_SEL); press(K_INC); press(K_INC); press(K_SEL); press(K_INC);
    check("s1_total", int'(total), 14);
    press(K_OK);
    check("s1_incoin", int'(state), S_INC);
    repeat (3) press(K_C5);
    check("s1_money", int'(money_in), 15);
    c5_0 = n_c5; c1_0 = n_c1; b0 = n_beep; o0 = n_out;
    press(K_OK);
    wait_state(S_RET, 200, "s1_to_return");
    check("s1_out_cycles", n_out - o0, 50);
    check("s1_change", int'(change), 1);
    check("s1_led", int'(led), 4'b1110);
    wait_state(S_IDLE, 20, "s1_to_idle");
    check("s1_coin1_count", n_c1 - c1_0, 1);
    check("s1_coin5_count", n_c5 - c5_0, 0);
    check("s1_beep_count", n_beep - b0, 1);

    // Underpay item1, top up during WAIT, change 7 = one 5 then two 1s.
    press(K_SEL); press(K_SEL); press(K_INC);
    check("s2_total", int'(total), 8);
    press(K_OK); press(K_C1); press(K_C1);
    press(K_OK);
    check("s2_wait", int'(state), S_WAIT);
    press(K_C5); press(K_C5); press(K_C1); press(K_C1); press(K_C1);
    check("s2_money", int'(money_in), 15);
    c5_0 = n_c5; c1_0 = n_c1;
    wait_state(S_OUT, 100, "s2_to_out");
    wait_state(S_RET, 100, "s2_to_return");
    check("s2_change", int'(change), 7);
    @(negedge clk);
    check("s2_first_coin5", int'(coin5_ret), 1);
    wait_state(S_IDLE, 20, "s2_to_idle");
    check("s2_coin5_count", n_c5 - c5_0, 1);
    check("s2_coin1_count", n_c1 - c1_0, 2);

    // Underpay item3 and let WAIT expire: full refund of 5.
    press(K_SEL); repeat (3) press(K_SEL); press(K_INC);
    check("s3_sel", int'(sel_idx), 3);
    check("s3_total", int'(total), 20);
    press(K_OK); press(K_C5);
    c5_0 = n_c5; c1_0 = n_c1; w0 = n_wait;
    press(K_OK);
    wait_state(S_RET, 100, "s3_to_return");
    check("s3_wait_cycles", n_wait - w0, 50);
    check("s3_change", int'(change), 5);
    check("s3_led", int'(led), 4'b0111);
    wait_state(S_IDLE, 20, "s3_to_idle");
    check("s3_coin5_count", n_c5 - c5_0, 1);
    check("s3_coin1_count", n_c1 - c1_0, 0);

    // Quantity saturation and selection wrap, then cancel.
    press(K_SEL);
    repeat (20) press(K_INC);
    check("s4_qty_sat", int'(qty_sel), 15);
    check("s4_total", int'(total), 45);
    repeat (4) press(K_SEL);
    check("s4_sel_wrap", int'(sel_idx), 0);
    press(K_CAN);
    check("s4_idle", int'(state), S_IDLE);
    check("s4_total_clr", int'(total), 0);

    // Simultaneous coins add 6; ok+cancel together means cancel.
    press(K_SEL); press(K_INC); press(K_OK);
    press(K_C1 | K_C5);
    check("s5_money", int'(money_in), 6);
    hit(K_OK | K_CAN);
    check("s5_return", int'(state), S_RET);
    check("s5_change", int'(change), 6);
    wait_state(S_IDLE, 20, "s5_to_idle");

    // Reset while change 12 is pending: no coins may come out.
    press(K_SEL); press(K_INC); press(K_OK);
    press(K_C5); press(K_C5); press(K_C1); press(K_C1);
    hit(K_CAN);
    check("s6_return", int'(state), S_RET);
    check("s6_change", int'(change), 12);
    c5_0 = n_c5; c1_0 = n_c1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_idle", int'(state), S_IDLE);
    check("s6_change_clr", int'(change), 0);
    check("s6_money_clr", int'(money_in), 0);
    repeat (5) @(negedge clk);
    check("s6_no_coins", (n_c5 - c5_0) + (n_c1 - c1_0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
